// File: rtl/prt_access_pkg.sv
// prt_access_pkg: shared types and default constants for the PRT bit-table access controller
package prt_access_pkg;
    localparam int PRT_ADDR_W = 16;
    localparam int PRT_RD_LAT = 2;
    localparam int PRT_ID_W   = 3;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic                valid;
        logic [PRT_ID_W-1:0] id;
    } rsp_ent_t;
endpackage

// File: rtl/prt_access_if.sv
// prt_access_if: requester-side bundle of the PRT access controller
//   req_valid/req_we/req_addr/req_wdata : requests from NUM_REQ engines
//   req_ready                           : one-hot grant
//   rsp_valid/rsp_data                  : read response pulse and shared data bit
interface prt_access_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/prt_rr_arbiter.sv
// prt_rr_arbiter: combinational round-robin grant
//   i_req    : request vector
//   i_ptr    : index of the last granted requester (search starts at i_ptr+1)
//   o_gnt    : one-hot grant
//   o_gnt_id : index of the granted requester
module prt_rr_arbiter
    import prt_access_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [PRT_ID_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic [PRT_ID_W-1:0] o_gnt_id
);
    always_comb begin
        logic found;
        o_gnt    = '0;
        o_gnt_id = '0;
        found    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++)
            for (int j = 0; j < NUM_REQ; j++)
                if (!found && i_req[j] && j == (int'(i_ptr) + k) % NUM_REQ) begin
                    o_gnt[j] = 1'b1;
                    o_gnt_id = PRT_ID_W'(j);
                    found    = 1'b1;
                end
    end
endmodule

// File: rtl/prt_access_ctrl.sv
// prt_access_ctrl: round-robin single-port access controller for the PRT bit-table BRAM
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : requester handshake and read responses
//   i_clr_start       : start a full table clear
//   o_busy            : clear in progress
//   o_bram_*          : registered BRAM port, i_bram_dout is its read data
// Optional feature: define PRT_ACCESS_CLEAR_EN to clear the table after reset and on i_clr_start.
module prt_access_ctrl
    import prt_access_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = PRT_ADDR_W,
    parameter int RD_LAT  = PRT_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    prt_access_if.slave       bus,
    input  logic              i_clr_start,
    output logic              o_busy,
    output logic              o_bram_en,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_din,
    input  logic              i_bram_dout
);
    state_t                r_state, w_next;
    logic [PRT_ID_W-1:0]   r_ptr, w_gnt_id;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_xfer, w_we, w_wdata, w_clr;
    logic [ADDR_W-1:0]     w_addr, w_clr_addr;
    rsp_ent_t              r_pipe [RD_LAT+1];
    rsp_ent_t              w_out;

`ifdef PRT_ACCESS_CLEAR_EN
    localparam state_t RST_ST = ST_CLEAR;
    logic [ADDR_W-1:0] r_cnt;
    assign w_clr      = r_state == ST_CLEAR;
    assign w_clr_addr = r_cnt;
    // Wraps to zero on its own after the last address, ready for the next clear.
    always_ff @(posedge clk)
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_clr ? r_cnt + 1'b1 : '0;
`else
    localparam state_t RST_ST = ST_RUN;
    logic w_unused_clr;
    assign w_unused_clr = i_clr_start;
    assign w_clr        = 1'b0;
    assign w_clr_addr   = '0;
`endif

    prt_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req    (bus.req_valid & {NUM_REQ{~w_clr}}),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign bus.req_ready = w_gnt;
    assign w_xfer        = |w_gnt;
    assign w_we          = |(bus.req_we & w_gnt);
    assign w_wdata       = |(bus.req_wdata & w_gnt);
    assign o_busy        = w_clr;

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_addr = w_addr | (bus.req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_gnt[i]}});
    end

    always_comb begin
        w_next = r_state;
`ifdef PRT_ACCESS_CLEAR_EN
        if (r_state == ST_CLEAR) w_next = (&r_cnt) ? ST_RUN : ST_CLEAR;
        else                     w_next = i_clr_start ? ST_CLEAR : ST_RUN;
`else
        w_next = ST_RUN;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RST_ST;
            r_ptr       <= PRT_ID_W'(NUM_REQ - 1);
            o_bram_en   <= 1'b0;
            o_bram_we   <= 1'b0;
            o_bram_addr <= '0;
            o_bram_din  <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) r_ptr <= w_gnt_id;
            if (w_clr) begin
                o_bram_en   <= 1'b1;
                o_bram_we   <= 1'b1;
                o_bram_addr <= w_clr_addr;
                o_bram_din  <= 1'b0;
            end else begin
                o_bram_en <= w_xfer;
                o_bram_we <= w_xfer & w_we;
                if (w_xfer) begin
                    o_bram_addr <= w_addr;
                    o_bram_din  <= w_wdata;
                end
            end
            // Stage 0 aligns with the registered BRAM address; stage RD_LAT with bram_dout.
            r_pipe[0] <= '{valid: w_xfer & ~w_we, id: w_gnt_id};
            for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_out         = r_pipe[RD_LAT];
    assign bus.rsp_valid = w_out.valid ? NUM_REQ'(1) << w_out.id : '0;
    assign bus.rsp_data  = w_out.valid & i_bram_dout;
endmodule
